// File: rtl/operand_packer.sv
// operand_packer: transposes a stream of operands into bit-plane
// layout and issues one parallel-load per batch to the accumulator.
module operand_packer #(
   parameter int m = 3,
   parameter int n = 2,
   parameter int k = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   in_valid,
   input  logic [m+n-1:0]         in_data,
   output logic                   in_ready,
   input  logic                   flush,
   input  logic                   acc_ready,
   output logic                   pl,
   output logic [(m+n)*k-1:0]     din,
   output logic                   busy
);

   localparam int W  = m + n;
   localparam int CD = k + 2;
   localparam int CW = $clog2(k) + 1;
   localparam int DW = $clog2(CD) + 1;
   localparam int SW = (k > 1) ? $clog2(k) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(k - 1);
   localparam logic [DW-1:0] COOL_MAX = DW'(CD);
   localparam logic [k-1:0]  SLOT_ONE = k'(1);

   typedef enum logic {
      FILL,
      ISSUE
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [DW-1:0]          cool;
   logic [W-1:0][k-1:0]    pbuf;
   logic [W-1:0][k-1:0]    pbuf_nxt;
   logic [k-1:0]           slot_oh;
   logic                   xfer;
   logic                   close;

   assign in_ready = (state == FILL);
   assign xfer     = in_valid && in_ready;
   assign pl       = (state == ISSUE) && acc_ready && (cool == '0);
   assign busy     = (state == ISSUE) || (cool != '0);
   assign din      = pbuf;

   // one-hot slot for the word being written in this batch
   assign slot_oh = SLOT_ONE << cnt[SW-1:0];

   // batch closes on the k-th word, or on flush with at least one word
   assign close = (state == FILL) &&
                  ((xfer && (cnt == CNT_LAST)) ||
                   (flush && (xfer || (cnt != '0))));

   // slots are written once per batch, so OR-ing in the new bit suffices
   for (genvar g = 0; g < W; g++) begin : g_plane
      assign pbuf_nxt[g] = pbuf[g] | (in_data[g] ? slot_oh : '0);
   end

   // hold-off counter: reload on every load strobe, then count down
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cool <= '0;
      end else if (pl) begin
         cool <= COOL_MAX;
      end else if (cool != '0) begin
         cool <= cool - 1'b1;
      end
   end

   // fill/issue sequencing and bit-plane buffer
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= FILL;
         cnt   <= '0;
         pbuf  <= '0;
      end else begin
         unique case (state)
            FILL: begin
               if (xfer) begin
                  pbuf <= pbuf_nxt;
                  cnt  <= cnt + 1'b1;
               end
               if (close) begin
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (pl) begin
                  pbuf  <= '0;
                  cnt   <= '0;
                  state <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
